// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: 2-flop sync, per-bit glitch filter, sticky edge capture, maskable level irq.
// Read latency 1 cycle, capture 3 cycles after input sampling (+FILTER_CYCLES-1); no backpressure, slave always accepts.
module pio_in_edge_irq #(
  parameter int WIDTH         = 1,
  parameter int EDGE_TYPE     = 0,
  parameter int FILTER_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2, filt, filt_d;
  logic [WIDTH-1:0] mask, capture, edge_evt, clr, wdat;
  logic [CW-1:0]    cnt [WIDTH];
  logic             wr;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wdat      = writedata[WIDTH-1:0];
  assign clr       = (wr && address == 2'd2) ? wdat : '0;
  assign unused_wd = ^writedata;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_evt = filt & ~filt_d;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_evt = ~filt & filt_d;
    end else begin : g_any
      assign edge_evt = filt ^ filt_d;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      filt_d <= '0;
    end else begin
      s1     <= in_port;
      s2     <= s1;
      filt_d <= filt;
    end
  end

  // A bit only moves once s2 has disagreed with it for FILTER_CYCLES evaluations in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = filt;
      2'd1:    rd_mux[WIDTH-1:0] = mask;
      2'd2:    rd_mux[WIDTH-1:0] = capture;
      default: rd_mux[WIDTH-1:0] = s2;
    endcase
  end

  // New events are OR-ed in after the clear so a coincident event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask     <= '0;
      capture  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && address == 2'd1) mask <= wdat;
      capture  <= (capture & ~clr) | edge_evt;
      readdata <= rd_mux;
      irq      <= |(capture & mask);
    end
  end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Scoreboarded random + directed bench for pio_in_edge_irq across three parameter sets.
module tb_pio_in_edge_irq;

  localparam int N = 3;
  int P_W [N] = '{8, 5, 32};
  int P_E [N] = '{0, 2, 1};
  int P_F [N] = '{1, 4, 3};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] in_bus = '0;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;
  logic        rst_drv = 1'b1;

  always #5 clk = ~clk;

  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .FILTER_CYCLES(1)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_bus[7:0]), .readdata(rd0), .irq(irq0));
  pio_in_edge_irq #(.WIDTH(5), .EDGE_TYPE(2), .FILTER_CYCLES(4)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_bus[4:0]), .readdata(rd1), .irq(irq1));
  pio_in_edge_irq #(.WIDTH(32), .EDGE_TYPE(1), .FILTER_CYCLES(3)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_bus), .readdata(rd2), .irq(irq2));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [N-1:0][31:0] rd;
    logic [N-1:0]       irq;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_s1 [N], m_s2 [N], m_filt [N], m_filtd [N], m_cap [N], m_mask [N], m_rd [N];
  logic        m_irq [N];
  int          m_run [N][32];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endfunction

  function automatic logic [31:0] wmask(int k);
    return (P_W[k] == 32) ? 32'hFFFF_FFFF : ((32'h1 << P_W[k]) - 32'h1);
  endfunction

  function automatic logic [31:0] get_rd(int k);
    return (k == 0) ? rd0 : (k == 1) ? rd1 : rd2;
  endfunction

  function automatic logic get_irq(int k);
    return (k == 0) ? irq0 : (k == 1) ? irq1 : irq2;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_filt[k] = '0; m_filtd[k] = '0;
      m_cap[k] = '0; m_mask[k] = '0; m_rd[k] = '0; m_irq[k] = 1'b0;
      for (int b = 0; b < 32; b++) m_run[k][b] = 0;
    end
  endfunction

  // One clock edge of the reference: every next value is derived from pre-edge state.
  function automatic void model_step();
    logic        wr;
    logic [31:0] mw, ev, clr, nf;
    exp_t        e;
    wr = chipselect && !write_n;
    if (reset) model_reset();
    else begin
      for (int k = 0; k < N; k++) begin
        mw = wmask(k);
        case (P_E[k])
          0:       ev = m_filt[k] & ~m_filtd[k];
          1:       ev = ~m_filt[k] & m_filtd[k];
          default: ev = m_filt[k] ^ m_filtd[k];
        endcase
        ev  = ev & mw;
        clr = (wr && address == 2'd2) ? (writedata & mw) : 32'h0;
        case (address)
          2'd0:    m_rd[k] = m_filt[k];
          2'd1:    m_rd[k] = m_mask[k];
          2'd2:    m_rd[k] = m_cap[k];
          default: m_rd[k] = m_s2[k];
        endcase
        m_irq[k] = |(m_cap[k] & m_mask[k]);
        m_cap[k] = (m_cap[k] & ~clr) | ev;
        if (wr && address == 2'd1) m_mask[k] = writedata & mw;
        nf = m_filt[k];
        for (int b = 0; b < P_W[k]; b++) begin
          if (m_s2[k][b] != m_filt[k][b]) begin
            m_run[k][b]++;
            if (m_run[k][b] >= P_F[k]) begin
              nf[b] = m_s2[k][b];
              m_run[k][b] = 0;
            end
          end else m_run[k][b] = 0;
        end
        m_filtd[k] = m_filt[k];
        m_filt[k]  = nf;
        m_s2[k]    = m_s1[k];
        m_s1[k]    = in_bus & mw;
      end
    end
    for (int k = 0; k < N; k++) begin
      e.rd[k]  = m_rd[k];
      e.irq[k] = m_irq[k];
    end
    exp_q.push_back(e);
  endfunction

  task automatic cyc(input logic [1:0] a, input bit wr_en, input logic [31:0] wd, input logic [31:0] inp);
    logic was;
    int   sel;
    @(negedge clk);
    #2;
    was     = reset;
    reset   = rst_drv;
    address = a;
    if (wr_en) begin
      chipselect = 1'b1; write_n = 1'b0;
    end else begin
      sel = $urandom_range(0, 2);
      chipselect = (sel == 0);
      write_n    = (sel != 2);
    end
    writedata = wd;
    in_bus    = inp;
    if (!was && reset) begin
      #1;
      for (int k = 0; k < N; k++) begin
        check($sformatf("async_rst_rd%0d", k), get_rd(k), 32'h0);
        check($sformatf("async_rst_irq%0d", k), {31'h0, get_irq(k)}, 32'h0);
      end
      model_reset();
    end
    @(posedge clk);
    model_step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < N; k++) begin
          check($sformatf("sb_rd%0d", k), get_rd(k), e.rd[k]);
          check($sformatf("sb_irq%0d", k), {31'h0, get_irq(k)}, {31'h0, e.irq[k]});
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] inp;
    model_reset();
    // Basic rising capture on the 8-bit instance
    rst_drv = 1'b1;
    repeat (3) cyc(2'd0, 0, 32'h0, 32'h0);
    rst_drv = 1'b0;
    repeat (3) cyc(2'd0, 0, 32'h0, 32'h0);
    repeat (6) cyc(2'd0, 0, 32'h0, 32'h81);
    #1 check("t1_filt", rd0, 32'h81);
    cyc(2'd2, 0, 32'h0, 32'h81);
    #1 check("t1_cap", rd0, 32'h81);
    check("t1_irq_masked", {31'h0, irq0}, 32'h0);

    // Mask, partial clear, full clear
    cyc(2'd1, 1, 32'h1, 32'h81);
    cyc(2'd0, 0, 32'h0, 32'h81);
    #1 check("t2_irq_on", {31'h0, irq0}, 32'h1);
    cyc(2'd2, 1, 32'h80, 32'h81);
    cyc(2'd2, 0, 32'h0, 32'h81);
    #1 check("t2_cap", rd0, 32'h01);
    check("t2_irq_held", {31'h0, irq0}, 32'h1);
    cyc(2'd2, 1, 32'h01, 32'h81);
    cyc(2'd0, 0, 32'h0, 32'h81);
    cyc(2'd0, 0, 32'h0, 32'h81);
    #1 check("t2_irq_off", {31'h0, irq0}, 32'h0);

    // Glitch filter on the FILTER_CYCLES=4 instance
    repeat (8) cyc(2'd0, 0, 32'h0, 32'h0);
    cyc(2'd2, 1, 32'hFFFF_FFFF, 32'h0);
    repeat (3) cyc(2'd3, 0, 32'h0, 32'h1);
    repeat (8) begin
      cyc(2'd0, 0, 32'h0, 32'h0);
      #1 check("t3_short_filt", rd1 & 32'h1, 32'h0);
    end
    cyc(2'd2, 0, 32'h0, 32'h0);
    #1 check("t3_short_cap", rd1 & 32'h1, 32'h0);
    repeat (4) cyc(2'd0, 0, 32'h0, 32'h1);
    repeat (8) cyc(2'd0, 0, 32'h0, 32'h0);
    cyc(2'd2, 0, 32'h0, 32'h0);
    #1 check("t3_long_cap", rd1 & 32'h1, 32'h1);

    // Any-edge capture with a clear landing on the same edge as the event
    cyc(2'd2, 1, 32'h4, 32'h0);
    repeat (6) cyc(2'd0, 0, 32'h0, 32'h4);
    cyc(2'd2, 1, 32'h4, 32'h4);
    cyc(2'd2, 0, 32'h0, 32'h4);
    #1 check("t4_rise_keep", rd1 & 32'h4, 32'h4);
    cyc(2'd2, 1, 32'h4, 32'h4);
    cyc(2'd2, 0, 32'h0, 32'h4);
    #1 check("t4_cleared", rd1 & 32'h4, 32'h0);
    repeat (18) cyc(2'd0, 0, 32'h0, 32'h4);
    repeat (10) cyc(2'd0, 0, 32'h0, 32'h0);
    cyc(2'd2, 0, 32'h0, 32'h0);
    #1 check("t4_fall_cap", rd1 & 32'h4, 32'h4);

    // Inputs high across reset release
    rst_drv = 1'b1;
    repeat (3) cyc(2'd2, 0, 32'h0, 32'hFFFF_FFFF);
    rst_drv = 1'b0;
    repeat (10) cyc(2'd2, 0, 32'h0, 32'hFFFF_FFFF);
    #1 check("t5_cap_w8", rd0, 32'hFF);
    check("t5_cap_w5", rd1, 32'h1F);
    check("t5_cap_fall", rd2, 32'h0);

    // Width truncation and read-only data register
    cyc(2'd1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc(2'd1, 0, 32'h0, 32'hFFFF_FFFF);
    #1 check("t6_mask_w32", rd2, 32'hFFFF_FFFF);
    check("t6_mask_w5", rd1, 32'h1F);
    check("t6_mask_w8", rd0, 32'hFF);
    cyc(2'd0, 1, 32'h0, 32'hFFFF_FFFF);
    cyc(2'd0, 0, 32'h0, 32'hFFFF_FFFF);
    #1 check("t6_ro_w32", rd2, 32'hFFFF_FFFF);

    // Randomised traffic
    inp = 32'hFFFF_FFFF;
    for (int i = 0; i < 3000; i++) begin
      inp = inp ^ ($urandom() & $urandom() & $urandom());
      rst_drv = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0)
        cyc(2'($urandom_range(0, 3)), 1,
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom(), inp);
      else
        cyc(2'($urandom_range(0, 3)), 0, $urandom(), inp);
    end
    rst_drv = 1'b0;
    repeat (3) cyc(2'd0, 0, 32'h0, inp);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
